// File: rtl/brute_force_matcher_multi_slot_buffer_control.sv
// Purpose: ring of keypoint descriptor slots preloaded from the secondary sync FIFO while the matcher reads another slot.
// Latency: load init one cycle after trigger, RAM writes from the next cycle, slot valid C_ELEMS_PER_KP+2 cycles after trigger.
// Backpressure: buffer_load_valid low stalls a load indefinitely; a full ring holds off new loads until keypoint_advance.
module brute_force_matcher_multi_slot_buffer_control #(
   parameter int C_NUM_SLOTS           = 2,
   parameter int C_ELEMS_PER_KP        = 4,
   parameter int C_SEC_DESC_FIFO_DEPTH = 32,
   parameter int C_FIFO_COUNT_WIDTH    = 18,
   localparam int SLOT_W = (C_NUM_SLOTS > 1) ? $clog2(C_NUM_SLOTS) : 1,
   localparam int ADDR_W = $clog2(C_ELEMS_PER_KP),
   localparam int OCC_W  = $clog2(C_NUM_SLOTS + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [C_FIFO_COUNT_WIDTH-1:0] fifo_count,
   output logic                          queue_depleted,
   output logic                          queue_space_available,
   input  logic                          keypoint_advance,
   output logic                          descriptor_valid,
   output logic [SLOT_W-1:0]             rd_slot,
   output logic                          buffer_load_init,
   output logic                          buffer_load_enable,
   input  logic                          buffer_load_valid,
   output logic [SLOT_W-1:0]             buffer_load_slot,
   output logic [ADDR_W-1:0]             buffer_load_addr,
   output logic [OCC_W-1:0]              occupancy
);

   // Space check is done one bit wider and signed so an over-full count reads as "no space" instead of wrapping.
   localparam int CW = C_FIFO_COUNT_WIDTH + 1;
   localparam logic signed [CW-1:0]         DEPTH_S   = CW'(C_SEC_DESC_FIFO_DEPTH);
   localparam logic signed [CW-1:0]         NEED_S    = CW'(2 * C_ELEMS_PER_KP);
   localparam logic [OCC_W-1:0]             OCC_FULL  = OCC_W'(C_NUM_SLOTS);
   localparam logic [C_FIFO_COUNT_WIDTH-1:0] KP_WORDS = C_FIFO_COUNT_WIDTH'(C_ELEMS_PER_KP);
   localparam logic [ADDR_W-1:0]            LAST_ADDR = ADDR_W'(C_ELEMS_PER_KP - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INIT,
      ST_LOAD,
      ST_SETTLE
   } state_t;

   state_t                 state;
   logic [SLOT_W-1:0]      wr_ptr;
   logic [SLOT_W-1:0]      rd_ptr;
   logic [ADDR_W-1:0]      load_count;
   logic                   load_start;
   logic                   load_done;
   logic                   advance_ok;
   logic signed [CW-1:0]   space_diff;

   // Slot count is a power of two, so pointer wrap is the natural carry-out (a single slot never moves).
   function automatic logic [SLOT_W-1:0] ptr_inc(input logic [SLOT_W-1:0] p);
      if (C_NUM_SLOTS == 1) return '0;
      return p + 1'b1;
   endfunction

   assign load_start = (occupancy < OCC_FULL) && (fifo_count >= KP_WORDS);
   assign load_done  = (state == ST_LOAD) && buffer_load_valid && (load_count == LAST_ADDR);
   assign advance_ok = keypoint_advance && (occupancy != '0);

   assign space_diff            = DEPTH_S - $signed({1'b0, fifo_count});
   assign queue_space_available = (space_diff >= NEED_S);

   assign descriptor_valid = (occupancy != '0);
   assign queue_depleted   = (occupancy == '0) && (state == ST_IDLE);
   assign rd_slot          = rd_ptr;
   assign buffer_load_addr = load_count;
   assign buffer_load_slot = wr_ptr;

   // Loader FSM: trigger, init pulse, counted write beats into the write slot, then one settle cycle for fifo_count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= ST_IDLE;
         load_count         <= '0;
         wr_ptr             <= '0;
         buffer_load_init   <= 1'b0;
         buffer_load_enable <= 1'b0;
      end else if (flush) begin
         state              <= ST_IDLE;
         load_count         <= '0;
         wr_ptr             <= '0;
         buffer_load_init   <= 1'b0;
         buffer_load_enable <= 1'b0;
      end else begin
         buffer_load_init <= 1'b0;
         case (state)
            ST_IDLE: begin
               buffer_load_enable <= 1'b0;
               if (load_start) begin
                  state            <= ST_INIT;
                  buffer_load_init <= 1'b1;
               end
            end
            ST_INIT: begin
               load_count         <= '0;
               buffer_load_enable <= 1'b1;
               state              <= ST_LOAD;
            end
            ST_LOAD: begin
               if (buffer_load_valid) begin
                  if (load_count == LAST_ADDR) begin
                     load_count         <= '0;
                     wr_ptr             <= ptr_inc(wr_ptr);
                     buffer_load_enable <= 1'b0;
                     state              <= ST_SETTLE;
                  end else begin
                     load_count <= load_count + 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               state <= ST_IDLE;
            end
            default: begin
               state              <= ST_IDLE;
               buffer_load_enable <= 1'b0;
            end
         endcase
      end
   end

   // Occupancy and read pointer: a completed load and an accepted advance in the same cycle cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy <= '0;
         rd_ptr    <= '0;
      end else if (flush) begin
         occupancy <= '0;
         rd_ptr    <= '0;
      end else begin
         case ({load_done, advance_ok})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
         if (advance_ok) rd_ptr <= ptr_inc(rd_ptr);
      end
   end

endmodule

// File: tb/tb_brute_force_matcher_multi_slot_buffer_control.sv
// Purpose: self-checking bench for the multi-slot descriptor buffer controller (directed scenarios plus random run vs model).
// Latency: inputs driven at the falling edge, outputs sampled at the following falling edge.
// Backpressure: random buffer_load_valid gaps and keypoint_advance exercise stalls and a full ring.
module tb_brute_force_matcher_multi_slot_buffer_control;

   localparam int NS    = 2;
   localparam int EK    = 4;
   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [17:0] fifo_count = '0;
   logic        queue_depleted;
   logic        queue_space_available;
   logic        keypoint_advance = 1'b0;
   logic        descriptor_valid;
   logic        rd_slot;
   logic        buffer_load_init;
   logic        buffer_load_enable;
   logic        buffer_load_valid = 1'b0;
   logic        buffer_load_slot;
   logic [1:0]  buffer_load_addr;
   logic [1:0]  occupancy;

   int checks = 0;
   int passes = 0;

   // Reference model state: keypoints held, ring positions, loader phase (0 idle, 1 init, 2 loading, 3 settle), beats written.
   int m_occ, m_wr, m_rd, m_phase, m_beats;

   brute_force_matcher_multi_slot_buffer_control #(
      .C_NUM_SLOTS(NS), .C_ELEMS_PER_KP(EK), .C_SEC_DESC_FIFO_DEPTH(DEPTH), .C_FIFO_COUNT_WIDTH(18)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .fifo_count(fifo_count),
      .queue_depleted(queue_depleted), .queue_space_available(queue_space_available),
      .keypoint_advance(keypoint_advance), .descriptor_valid(descriptor_valid), .rd_slot(rd_slot),
      .buffer_load_init(buffer_load_init), .buffer_load_enable(buffer_load_enable),
      .buffer_load_valid(buffer_load_valid), .buffer_load_slot(buffer_load_slot),
      .buffer_load_addr(buffer_load_addr), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_occ = 0; m_wr = 0; m_rd = 0; m_phase = 0; m_beats = 0;
   endtask

   task automatic model_step(input bit f, input int fc, input bit v, input bit a);
      bit done, adv_ok;
      if (f) begin
         model_reset();
         return;
      end
      done   = (m_phase == 2) && v && (m_beats == EK - 1);
      adv_ok = a && (m_occ > 0);
      case (m_phase)
         0: if (m_occ < NS && fc >= EK) m_phase = 1;
         1: begin m_phase = 2; m_beats = 0; end
         2: if (v) begin if (done) m_phase = 3; else m_beats++; end
         default: m_phase = 0;
      endcase
      if (done) begin m_beats = 0; m_wr = (m_wr + 1) % NS; end
      if (adv_ok) m_rd = (m_rd + 1) % NS;
      m_occ = m_occ + int'(done) - int'(adv_ok);
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; keypoint_advance = 1'b0; buffer_load_valid = 1'b0; fifo_count = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1; fifo_count = 18'd24;
      @(negedge clk);
      checks++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else passes++;
      checks++; if (descriptor_valid !== 1'b0) $display("FAIL reset_desc_valid got %b want 0", descriptor_valid); else passes++;
      checks++; if (queue_depleted !== 1'b1) $display("FAIL reset_depleted got %b want 1", queue_depleted); else passes++;
      checks++; if ({buffer_load_init, buffer_load_enable, buffer_load_slot, buffer_load_addr, rd_slot} !== 6'b0)
         $display("FAIL reset_loader_outs got init=%b en=%b slot=%b addr=%0d rd=%b want all 0",
                  buffer_load_init, buffer_load_enable, buffer_load_slot, buffer_load_addr, rd_slot);
      else passes++;
      checks++; if (queue_space_available !== 1'b1) $display("FAIL reset_space got %b want 1", queue_space_available); else passes++;
   endtask

   task automatic test_space();
      logic [17:0] vals [6] = '{18'd32, 18'd24, 18'd40, 18'd0, 18'd25, 18'h3FFFF};
      logic        want [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         fifo_count = vals[i];
         #1;
         checks++;
         if (queue_space_available !== want[i])
            $display("FAIL space_fc%0d got %b want %b", vals[i], queue_space_available, want[i]);
         else passes++;
      end
   endtask

   task automatic test_single_load();
      do_reset();
      fifo_count = 18'd4; buffer_load_valid = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         checks++; if (buffer_load_init !== (k == 1)) $display("FAIL single_init_c%0d got %b", k, buffer_load_init); else passes++;
         checks++; if (buffer_load_enable !== (k >= 2 && k <= 5)) $display("FAIL single_en_c%0d got %b", k, buffer_load_enable); else passes++;
         if (k >= 2 && k <= 5) begin
            checks++;
            if (buffer_load_addr !== 2'(k - 2) || buffer_load_slot !== 1'b0)
               $display("FAIL single_addr_c%0d got addr=%0d slot=%b want addr=%0d slot=0", k, buffer_load_addr, buffer_load_slot, k - 2);
            else passes++;
         end
         checks++; if (descriptor_valid !== (k >= 6)) $display("FAIL single_dv_c%0d got %b", k, descriptor_valid); else passes++;
         if (k == 6) fifo_count = '0;
      end
      checks++; if (occupancy !== 2'd1) $display("FAIL single_occ got %0d want 1", occupancy); else passes++;
   endtask

   task automatic test_fill_ring();
      int nbeats = 0;
      bit slot_ok = 1'b1;
      bit idle_bad = 1'b0;
      do_reset();
      fifo_count = 18'd16; buffer_load_valid = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (buffer_load_enable) begin
            if (buffer_load_slot !== ((nbeats < EK) ? 1'b0 : 1'b1)) slot_ok = 1'b0;
            nbeats++;
         end
      end
      checks++; if (occupancy !== 2'd2) $display("FAIL ring_occ got %0d want 2", occupancy); else passes++;
      checks++; if (nbeats != 2 * EK) $display("FAIL ring_beats got %0d want %0d", nbeats, 2 * EK); else passes++;
      checks++; if (slot_ok !== 1'b1) $display("FAIL ring_slots got wrong slot order want 0 then 1"); else passes++;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (buffer_load_init || buffer_load_enable || queue_depleted !== 1'b0) idle_bad = 1'b1;
      end
      checks++; if (idle_bad !== 1'b0) $display("FAIL ring_full_idle got loader activity want none"); else passes++;
      keypoint_advance = 1'b1;
      @(negedge clk);
      keypoint_advance = 1'b0;
      checks++;
      if (occupancy !== 2'd1 || rd_slot !== 1'b1 || buffer_load_init !== 1'b0)
         $display("FAIL ring_advance got occ=%0d rd=%b init=%b want occ=1 rd=1 init=0", occupancy, rd_slot, buffer_load_init);
      else passes++;
      @(negedge clk);
      checks++; if (buffer_load_init !== 1'b1) $display("FAIL ring_resume_init got %b want 1", buffer_load_init); else passes++;
      @(negedge clk);
      checks++;
      if (buffer_load_enable !== 1'b1 || buffer_load_slot !== 1'b0)
         $display("FAIL ring_resume_load got en=%b slot=%b want en=1 slot=0", buffer_load_enable, buffer_load_slot);
      else passes++;
      fifo_count = '0;
   endtask

   task automatic test_back_to_back_advance();
      do_reset();
      fifo_count = 18'd4; buffer_load_valid = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 12) begin
            checks++;
            if (buffer_load_enable !== 1'b1 || buffer_load_addr !== 2'd3 || buffer_load_slot !== 1'b1 || occupancy !== 2'd1)
               $display("FAIL b2b_final_beat got en=%b addr=%0d slot=%b occ=%0d want 1,3,1,1",
                        buffer_load_enable, buffer_load_addr, buffer_load_slot, occupancy);
            else passes++;
         end
         if (k == 13) begin
            checks++;
            if (occupancy !== 2'd1 || rd_slot !== 1'b1)
               $display("FAIL b2b_simul got occ=%0d rd=%b want occ=1 rd=1", occupancy, rd_slot);
            else passes++;
         end
         if (k == 16) begin
            checks++;
            if (buffer_load_enable !== 1'b1 || buffer_load_slot !== 1'b0)
               $display("FAIL b2b_wr_wrap got en=%b slot=%b want en=1 slot=0", buffer_load_enable, buffer_load_slot);
            else passes++;
         end
         keypoint_advance = (k == 12);
      end
      fifo_count = '0;
   endtask

   task automatic test_stall();
      do_reset();
      fifo_count = 18'd4;
      for (int k = 0; k <= 9; k++) begin
         if (k >= 1) @(negedge clk);
         if (k >= 2 && k <= 8) begin
            checks++;
            if (buffer_load_enable !== 1'b1 || buffer_load_addr !== 2'((k - 1) / 2))
               $display("FAIL stall_c%0d got en=%b addr=%0d want en=1 addr=%0d", k, buffer_load_enable, buffer_load_addr, (k - 1) / 2);
            else passes++;
         end
         if (k == 9) begin
            checks++;
            if (occupancy !== 2'd1 || buffer_load_enable !== 1'b0)
               $display("FAIL stall_done got occ=%0d en=%b want occ=1 en=0", occupancy, buffer_load_enable);
            else passes++;
         end
         buffer_load_valid = (k % 2 == 0);
      end
      fifo_count = '0;
   endtask

   task automatic run_abort(input bit use_rst);
      bit saw_valid = 1'b0;
      bit found = 1'b0;
      do_reset();
      fifo_count = 18'd4; buffer_load_valid = 1'b1;
      for (int k = 1; k <= 11; k++) @(negedge clk);
      checks++;
      if (buffer_load_enable !== 1'b1 || buffer_load_slot !== 1'b1 || buffer_load_addr !== 2'd2)
         $display("FAIL abort%0d_pre got en=%b slot=%b addr=%0d want 1,1,2", use_rst, buffer_load_enable, buffer_load_slot, buffer_load_addr);
      else passes++;
      if (use_rst) begin
         #2 rst = 1'b1;
         #1;
         checks++;
         if (buffer_load_enable !== 1'b0 || occupancy !== 2'd0 || queue_depleted !== 1'b1 || descriptor_valid !== 1'b0)
            $display("FAIL abort_rst_async got en=%b occ=%0d depl=%b dv=%b want 0,0,1,0",
                     buffer_load_enable, occupancy, queue_depleted, descriptor_valid);
         else passes++;
         @(negedge clk);
         rst = 1'b0;
      end else begin
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         checks++;
         if (buffer_load_enable !== 1'b0 || occupancy !== 2'd0 || queue_depleted !== 1'b1 || descriptor_valid !== 1'b0)
            $display("FAIL abort_flush got en=%b occ=%0d depl=%b dv=%b want 0,0,1,0",
                     buffer_load_enable, occupancy, queue_depleted, descriptor_valid);
         else passes++;
      end
      for (int k = 0; k < 6 && !found; k++) begin
         @(negedge clk);
         if (descriptor_valid !== 1'b0) saw_valid = 1'b1;
         if (buffer_load_enable === 1'b1) found = 1'b1;
      end
      checks++; if (saw_valid !== 1'b0) $display("FAIL abort%0d_no_valid got descriptor_valid=1 want 0", use_rst); else passes++;
      checks++;
      if (!found || buffer_load_slot !== 1'b0 || buffer_load_addr !== 2'd0)
         $display("FAIL abort%0d_next_slot got found=%b slot=%b addr=%0d want found=1 slot=0 addr=0",
                  use_rst, found, buffer_load_slot, buffer_load_addr);
      else passes++;
      fifo_count = '0;
   endtask

   task automatic test_flush();
      run_abort(1'b0);
   endtask

   task automatic test_rst_midload();
      run_abort(1'b1);
   endtask

   task automatic test_random();
      bit f, v, a;
      int fc;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         checks++;
         if (occupancy !== 2'(m_occ) || rd_slot !== 1'(m_rd))
            $display("FAIL rand_occ_rd cyc%0d got occ=%0d rd=%b want occ=%0d rd=%0d", i, occupancy, rd_slot, m_occ, m_rd);
         else passes++;
         checks++;
         if (descriptor_valid !== (m_occ > 0) || queue_depleted !== (m_occ == 0 && m_phase == 0))
            $display("FAIL rand_status cyc%0d got dv=%b depl=%b", i, descriptor_valid, queue_depleted);
         else passes++;
         checks++;
         if (buffer_load_init !== (m_phase == 1) || buffer_load_enable !== (m_phase == 2))
            $display("FAIL rand_loader cyc%0d got init=%b en=%b phase=%0d", i, buffer_load_init, buffer_load_enable, m_phase);
         else passes++;
         if (m_phase == 2) begin
            checks++;
            if (buffer_load_addr !== 2'(m_beats) || buffer_load_slot !== 1'(m_wr))
               $display("FAIL rand_addr cyc%0d got addr=%0d slot=%b want addr=%0d slot=%0d",
                        i, buffer_load_addr, buffer_load_slot, m_beats, m_wr);
            else passes++;
         end
         checks++;
         if (queue_space_available !== ((DEPTH - int'(fifo_count)) >= 2 * EK))
            $display("FAIL rand_space cyc%0d got %b fc=%0d", i, queue_space_available, fifo_count);
         else passes++;
         f  = ($urandom_range(0, 99) == 0);
         fc = $urandom_range(0, 40);
         v  = ($urandom_range(0, 3) != 0);
         a  = ($urandom_range(0, 3) == 0);
         flush = f; fifo_count = 18'(fc); buffer_load_valid = v; keypoint_advance = a;
         model_step(f, fc, v, a);
      end
      flush = 1'b0; keypoint_advance = 1'b0;
   endtask

   initial begin
      test_reset();
      test_space();
      test_single_load();
      test_fill_ring();
      test_back_to_back_advance();
      test_stall();
      test_flush();
      test_rst_midload();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
